adc_coherent_avg: RTL

Parametrised coherent-averaging accumulator for the ADC front end. It sums 2^NT_LOG2 consecutive periods of NUM_P samples point-by-point and removes the offset-binary bias. Each completed averaged frame is buffered and streamed out over a valid/ready interface to the UART framer. Acquisition is never stalled by the consumer: completed frames are dropped and counted when the output buffer is still occupied.

---
 rtl/adc_coherent_avg.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/adc_coherent_avg.sv
// adc_coherent_avg: point-by-point coherent averaging of ADC periods with
// bias removal, a one-frame result buffer and a valid/ready output stream.
module adc_coherent_avg #(
    parameter int DATA_W    = 14,
    parameter int NUM_P     = 40,
    parameter int NT_LOG2   = 7,
    parameter int OUT_SHIFT = 5,
    parameter int OUT_W     = 16
) (
    input  logic              clk_40M,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [DATA_W-1:0] data_ain,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_first,
    output logic              m_last,
    output logic              frame_done,
    output logic              overrun,
    output logic [7:0]        ovr_cnt
);
    localparam int ACC_W = DATA_W + NT_LOG2;
    localparam int PW    = (NUM_P > 2) ? $clog2(NUM_P) : 1;
    localparam int SW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [PW-1:0]      P_LAST  = PW'(NUM_P - 1);
    localparam logic [NT_LOG2-1:0] T_LAST  = '1;
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_FULL
    } buf_t;

    logic [PW-1:0]           p;
    logic [NT_LOG2-1:0]      t;
    logic signed [ACC_W-1:0] acc  [NUM_P];
    logic [OUT_W-1:0]        rbuf [NUM_P];
    buf_t                    bstate;
    logic                    drop;
    logic [PW-1:0]           rd_p;

    logic signed [DATA_W-1:0] s;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shr;
    logic signed [SW-1:0]     shr_x;
    logic [OUT_W-1:0]         r;
    logic [PW-1:0]            rd_nxt;
    logic take, t_last, beat, release_buf, accept, wr;

    assign s           = $signed({~data_ain[DATA_W-1], data_ain[DATA_W-2:0]});
    assign sum         = acc[p] + ACC_W'(s);
    assign shr         = sum >>> OUT_SHIFT;
    assign shr_x       = SW'(shr);
    assign take        = en & ~restart;
    assign t_last      = (t == T_LAST);
    assign beat        = m_valid & m_ready;
    assign release_buf = beat & m_last;
    assign rd_nxt      = rd_p + 1'b1;

    // A finishing drain frees the buffer in time for a new frame.
    assign accept = (bstate == BUF_EMPTY) |
                    ((bstate == BUF_FULL) & release_buf);

    // Results are stored only for a frame that claimed the buffer at p=0.
    assign wr = take & t_last &
                ((p == '0) ? accept : (bstate == BUF_FILLING));

    // Saturate the scaled sum into the signed output range.
    always_comb begin
        r = shr_x[OUT_W-1:0];
        if (shr_x > SAT_MAX) begin
            r = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shr_x < SAT_MIN) begin
            r = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // Point and pass counters.
    always_ff @(posedge clk_40M) begin
        if (rst) begin
            p <= '0;
            t <= '0;
        end else if (restart) begin
            p <= '0;
            t <= '0;
        end else if (en) begin
            if (p == P_LAST) begin
                p <= '0;
                t <= t + 1'b1;
            end else begin
                p <= p + 1'b1;
            end
        end
    end

    // Pass 0 overwrites, so the accumulator needs no clear cycle.
    always_ff @(posedge clk_40M) begin
        if (take && !t_last) begin
            acc[p] <= (t == '0) ? ACC_W'(s) : sum;
        end
    end

    // Result buffer write on the final pass.
    always_ff @(posedge clk_40M) begin
        if (wr) begin
            rbuf[p] <= r;
        end
    end

    // Buffer state, drop accounting and output stream.
    always_ff @(posedge clk_40M) begin
        if (rst) begin
            bstate     <= BUF_EMPTY;
            drop       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            ovr_cnt    <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_first    <= 1'b0;
            m_last     <= 1'b0;
            rd_p       <= '0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;

            if (bstate == BUF_FULL && !m_valid) begin
                m_valid <= 1'b1;
                m_data  <= rbuf[0];
                m_first <= 1'b1;
                m_last  <= 1'b0;
                rd_p    <= '0;
            end else if (beat) begin
                if (m_last) begin
                    m_valid <= 1'b0;
                    m_first <= 1'b0;
                    m_last  <= 1'b0;
                    bstate  <= BUF_EMPTY;
                end else begin
                    rd_p    <= rd_nxt;
                    m_data  <= rbuf[rd_nxt];
                    m_first <= 1'b0;
                    m_last  <= (rd_nxt == P_LAST);
                end
            end

            if (restart) begin
                drop <= 1'b0;
                if (bstate == BUF_FILLING) begin
                    bstate <= BUF_EMPTY;
                end
            end else if (en && t_last) begin
                if (p == '0) begin
                    drop <= ~accept;
                    if (accept) begin
                        bstate <= BUF_FILLING;
                    end
                end else if (p == P_LAST) begin
                    if (bstate == BUF_FILLING) begin
                        bstate     <= BUF_FULL;
                        frame_done <= 1'b1;
                    end
                    if (drop) begin
                        drop    <= 1'b0;
                        overrun <= 1'b1;
                        if (ovr_cnt != 8'hFF) begin
                            ovr_cnt <= ovr_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
